vga_fb_arbiter: RTL

//  Shares one single-port framebuffer SRAM between the VGA display read stream and a

---
 rtl/vga_fb_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: display reads take priority, and one buffered host request issues in free cycles.
// Optional macro VGA_FB_BLANK_ONLY_EN restricts host issue to blanking cycles.
module vga_fb_arbiter #(
  parameter int AW       = 18,
  parameter int DW       = 12,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          blank,
  output logic          host_starve,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dbg_state
);

  // Handshake: a host request transfers on a rising edge where host_valid && host_ready.
  // host_ready depends only on registered state, never on host_valid.
  typedef enum logic {S_EMPTY = 1'b0, S_PEND = 1'b1} state_t;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t          state_q, state_d;
  logic            buf_we;
  logic [AW-1:0]   buf_addr;
  logic [DW-1:0]   buf_wdata;
  logic            accept;
  logic            issue_host;
  logic            host_slot;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      tag_q;
  logic [1:0]      tag_pipe [MEM_LAT];

`ifdef VGA_FB_BLANK_ONLY_EN
  assign host_slot = blank & ~disp_req;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign host_slot    = ~disp_req;
`endif

  always_comb begin
    state_d    = state_q;
    host_ready = 1'b0;
    accept     = 1'b0;
    issue_host = 1'b0;
    case (state_q)
      S_EMPTY: begin
        host_ready = 1'b1;
        accept     = host_valid;
        if (host_valid) state_d = S_PEND;
      end
      S_PEND: begin
        issue_host = host_slot;
        if (host_slot) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (accept) begin
      buf_we    <= host_we;
      buf_addr  <= host_addr;
      buf_wdata <= host_wdata;
    end
  end

  // SRAM command register; the tag records who owns any read data coming back.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_q     <= 2'b00;
    end else begin
      mem_en    <= disp_req | issue_host;
      mem_we    <= issue_host & buf_we;
      mem_addr  <= disp_req ? disp_addr : (issue_host ? buf_addr : '0);
      mem_wdata <= issue_host ? buf_wdata : '0;
      tag_q     <= {disp_req, issue_host & ~buf_we};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tag_pipe[i] <= 2'b00;
    end else begin
      tag_pipe[0] <= tag_q;
      for (int i = 1; i < MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign disp_rvalid = tag_pipe[MEM_LAT-1][1];
  assign host_rvalid = tag_pipe[MEM_LAT-1][0];
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  // Starvation is flagged on the edge where the pending count reaches MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst || clear || issue_host) begin
      wait_cnt <= '0;
    end else if (state_q == S_PEND && wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      host_starve <= 1'b0;
    end else if (state_q == S_PEND && !issue_host && wait_cnt >= CW'(MAX_WAIT - 1)) begin
      host_starve <= 1'b1;
    end
  end

  assign dbg_state = (state_q == S_PEND);

endmodule
